// File: rtl/iot_ser_pkg.sv
// iot_ser_pkg: shared types, constants and CRC-8 helper for the IOT result serializer.
package iot_ser_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2,
        CRC  = 2'd3
    } ser_state_t;

    localparam int BYTES_PER_WORD = 16;
    localparam logic [7:0] CRC8_POLY = 8'h07;
    localparam logic [7:0] CRC8_INIT = 8'h00;

    // One byte of MSB-first CRC-8, no reflection.
    function automatic logic [7:0] crc8_update(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++)
            c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
        return c;
    endfunction

endpackage

// File: rtl/iot_ser_fifo.sv
// iot_ser_fifo: result-word FIFO; a push while full is dropped (even with a pop) and sets sticky overflow.
module iot_ser_fifo
    import iot_ser_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 128
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_overflow
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [AW:0]      r_level;
    logic             r_overflow;
    logic             w_full;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_full     = r_level == (AW+1)'(DEPTH);
    assign w_do_push  = i_push && !w_full;
    assign w_do_pop   = i_pop && (r_level != '0);
    assign o_data     = r_mem[r_rd];
    assign o_level    = r_level;
    assign o_overflow = r_overflow;

    always_ff @(posedge clk) begin
        if (w_do_push)
            r_mem[r_wr] <= i_data;
    end

    // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr       <= '0;
            r_rd       <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_wr       <= w_do_push ? r_wr + 1'b1 : r_wr;
            r_rd       <= w_do_pop ? r_rd + 1'b1 : r_rd;
            r_level    <= r_level + (AW+1)'(w_do_push) - (AW+1)'(w_do_pop);
            r_overflow <= r_overflow || (i_push && w_full);
        end
    end

endmodule

// File: rtl/iot_out_serializer.sv
// iot_out_serializer: buffers 128-bit result words and streams each as an MSB-first byte frame.
// Define IOT_SER_CRC8_EN to append a CRC-8 (poly 0x07) byte to every frame.
module iot_out_serializer
    import iot_ser_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [127:0]           in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [7:0]             out_data,
    output logic                   out_last,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow
);

    ser_state_t   r_state;
    ser_state_t   w_next;
    logic [127:0] r_shift;
    logic [3:0]   r_cnt;
    logic [127:0] w_head;
    logic         w_fire;
    logic         w_pop;
    logic         w_last_data;
`ifdef IOT_SER_CRC8_EN
    logic [7:0]   r_crc;
    localparam ser_state_t FRAME_TAIL = CRC;
`else
    localparam ser_state_t FRAME_TAIL = IDLE;
`endif

    assign w_fire      = out_valid && out_ready;
    assign w_pop       = r_state == LOAD;
    assign w_last_data = r_cnt == 4'(BYTES_PER_WORD - 1);

    iot_ser_fifo #(.DEPTH(DEPTH), .WIDTH(128)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_push     (in_valid),
        .i_data     (in_data),
        .i_pop      (w_pop),
        .o_data     (w_head),
        .o_level    (level),
        .o_overflow (overflow)
    );

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: w_next = (level != '0) ? LOAD : IDLE;
            LOAD: w_next = SEND;
            SEND: w_next = (w_fire && w_last_data) ? FRAME_TAIL : SEND;
`ifdef IOT_SER_CRC8_EN
            CRC:  w_next = w_fire ? IDLE : CRC;
`else
            default: w_next = IDLE;
`endif
        endcase
    end

    always_comb begin
`ifdef IOT_SER_CRC8_EN
        out_valid = (r_state == SEND) || (r_state == CRC);
        out_data  = (r_state == CRC) ? r_crc : r_shift[127:120];
        out_last  = r_state == CRC;
`else
        out_valid = r_state == SEND;
        out_data  = r_shift[127:120];
        out_last  = (r_state == SEND) && w_last_data;
`endif
    end

    // The shift register only advances on an accepted byte, keeping out_data steady under backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift <= '0;
            r_cnt   <= '0;
`ifdef IOT_SER_CRC8_EN
            r_crc   <= CRC8_INIT;
`endif
        end else if (r_state == LOAD) begin
            r_shift <= w_head;
            r_cnt   <= '0;
`ifdef IOT_SER_CRC8_EN
            r_crc   <= CRC8_INIT;
`endif
        end else if (r_state == SEND && w_fire) begin
            r_shift <= {r_shift[119:0], 8'h00};
            r_cnt   <= r_cnt + 4'd1;
`ifdef IOT_SER_CRC8_EN
            r_crc   <= crc8_update(r_crc, r_shift[127:120]);
`endif
        end
    end

endmodule

// File: tb/tb_iot_out_serializer.sv
// tb_iot_out_serializer: randomized directed bench with a queue-based frame model and long-division CRC reference.
module tb_iot_out_serializer;

    localparam int DEPTH = 4;
`ifdef IOT_SER_CRC8_EN
    localparam int FRAME = 17;
`else
    localparam int FRAME = 16;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic [127:0] in_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [7:0]   out_data;
    logic         out_last;
    logic [$clog2(DEPTH):0] level;
    logic         overflow;

    int tests = 0;
    int fails = 0;
    logic [8:0] got[$];
    logic [8:0] exp_q[$];
    logic [8:0] held;
    logic       held_v = 1'b0;

    iot_out_serializer #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .level     (level),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] obs, input logic [127:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, expv);
        end
    endtask

    // Sink side: record accepted bytes and verify stalled bytes are held.
    always @(negedge clk) begin
        if (rst) begin
            held_v = 1'b0;
        end else begin
            if (held_v && out_valid)
                check("stall_hold", {out_last, out_data}, held);
            if (out_valid && out_ready)
                got.push_back({out_last, out_data});
            held_v = out_valid && !out_ready;
            held = {out_last, out_data};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] crc_ref(input logic [127:0] w);
        logic [135:0] m;
        m = {w, 8'h00};
        for (int i = 135; i >= 8; i--)
            if (m[i]) m[i -: 9] = m[i -: 9] ^ 9'h107;
        return m[7:0];
    endfunction

    task automatic add_frame(input logic [127:0] w);
        for (int k = 0; k < 16; k++)
            exp_q.push_back({(k == 15) && (FRAME == 16), w[127 - 8*k -: 8]});
`ifdef IOT_SER_CRC8_EN
        exp_q.push_back({1'b1, crc_ref(w)});
`endif
    endtask

    task automatic push(input logic [127:0] w);
        in_valid = 1'b1;
        in_data = w;
        tick();
        in_valid = 1'b0;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic drain(input int n, input bit bp);
        logic [3:0] pat;
        int cyc;
        pat = 4'b1001;
        cyc = 0;
        while (got.size() < n && cyc < 3000) begin
            out_ready = bp ? pat[3 - (cyc % 4)] : 1'b1;
            tick();
            cyc++;
        end
        out_ready = 1'b1;
        repeat (4) tick();
        check("drain_done", 128'(got.size() >= n), 128'd1);
    endtask

    task automatic compare(input string name);
        check({name, "_len"}, 128'(got.size()), 128'(exp_q.size()));
        for (int i = 0; i < got.size() && i < exp_q.size(); i++)
            check(name, got[i], exp_q[i]);
        got.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [127:0] w, blocker;
        logic [127:0] ws[5];
        repeat (2) tick();
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_last", out_last, 0);
        check("rst_level", level, 0);
        check("rst_ovf", overflow, 0);
        rst = 1'b0;
        tick();
        // Single known word: out_valid two edges after capture.
        w = 128'h000102030405060708090A0B0C0D0E0F;
        add_frame(w);
        push(w);
        check("lat_valid_e0", out_valid, 0);
        check("lat_level_e0", level, 1);
        tick();
        check("lat_valid_e1", out_valid, 0);
        tick();
        check("lat_valid_e2", out_valid, 1);
        check("lat_byte0", out_data, 8'h00);
        drain(FRAME, 1'b0);
        compare("single");
        // Back-to-back random words under 1,0,0,1 backpressure.
        for (int i = 0; i < 3; i++) begin
            w = rnd128();
            add_frame(w);
            push(w);
        end
        drain(3 * FRAME, 1'b1);
        compare("bp");
        // Overflow: a stalled frame holds the serializer while 5 words arrive.
        out_ready = 1'b0;
        blocker = rnd128();
        add_frame(blocker);
        push(blocker);
        repeat (3) tick();
        for (int i = 0; i < 5; i++) begin
            ws[i] = rnd128();
            if (i < 4) add_frame(ws[i]);
            push(ws[i]);
        end
        check("ovf_level", level, DEPTH);
        check("ovf_flag", overflow, 1);
        check("ovf_stall_valid", out_valid, 1);
        check("ovf_stall_byte", out_data, blocker[127:120]);
        drain(5 * FRAME, 1'b0);
        compare("ovf");
        check("ovf_sticky", overflow, 1);
        check("ovf_empty", level, 0);
        // Push coinciding with the LOAD pop keeps level at 2.
        for (int i = 0; i < 3; i++) ws[i] = rnd128();
        ws[1] = '0;
        for (int i = 0; i < 3; i++) add_frame(ws[i]);
        in_valid = 1'b1;
        in_data = ws[0];
        tick();
        in_data = ws[1];
        tick();
        check("pp_level_pre", level, 2);
        in_data = ws[2];
        tick();
        in_valid = 1'b0;
        check("pp_level_post", level, 2);
        drain(3 * FRAME, 1'b0);
        compare("pushpop");
        // Reset after byte 5 of a frame, with another word queued behind it.
        w = rnd128();
        push(w);
        push(rnd128());
        for (int k = 0; k < 6; k++) exp_q.push_back({1'b0, w[127 - 8*k -: 8]});
        for (int c = 0; c < 100 && got.size() < 6; c++) tick();
        rst = 1'b1;
        tick();
        check("mrst_valid", out_valid, 0);
        check("mrst_level", level, 0);
        check("mrst_ovf", overflow, 0);
        check("mrst_data", out_data, 0);
        rst = 1'b0;
        repeat (40) tick();
        check("mrst_idle", out_valid, 0);
        compare("midrst");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/iot_out_serializer.md
IOT_OUT_SERIALIZER -- requirements
Module: iot_out_serializer

Interface
REQ-001 SHALL have parameter DEPTH, default 4: result FIFO depth in 128-bit words; power of two, at least 2.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port in_valid, input, 1 bit: result-word strobe from the IOT data-filter stage (its valid output).
REQ-005 SHALL have port in_data, input, 128 bits: result word from the IOT data-filter stage (its iot_out output).
REQ-006 SHALL have port out_valid, output, 1 bit: out_data holds a byte.
REQ-007 SHALL have port out_ready, input, 1 bit: the sink accepts the byte.
REQ-008 SHALL have port out_data, output, 8 bits: serialized byte.
REQ-009 SHALL have port out_last, output, 1 bit: marks the final byte of a frame.
REQ-010 SHALL have port level, output, $clog2(DEPTH)+1 bits: FIFO occupancy.
REQ-011 SHALL have port overflow, output, 1 bit: sticky flag for a dropped word.

Function
REQ-012 SHALL capture in_data into the FIFO on a rising edge where in_valid=1 and level<DEPTH.
REQ-013 SHALL drop a word that arrives while level==DEPTH, and set overflow=1; this applies even if a pop occurs in the same cycle.
REQ-014 SHALL change level by 0 when a push and a pop occur in the same cycle.
REQ-015 SHALL wrap the FIFO read and write pointers modulo DEPTH.
REQ-016 SHALL implement an FSM with states IDLE, LOAD, SEND and CRC.
- IDLE -> LOAD when level>0.
- LOAD: pops the head word into a 128-bit shift register, with out_valid=0 for one cycle; then -> SEND.
- SEND: -> CRC (macro defined) or IDLE after byte 15 transfers.
- CRC: -> IDLE after the CRC byte transfers.
REQ-017 SHALL emit the bytes of a word MSB first: byte k = in_data[127-8k -: 8], for k = 0..15.
REQ-018 SHALL count a transfer only when out_valid=1 and out_ready=1 at a rising edge.
REQ-019 SHALL hold out_data and out_last stable while out_valid=1 and out_ready=0.
REQ-020 SHALL never deassert out_valid mid-frame.
REQ-021 SHALL assert out_valid with byte 0 in cycle t+2, given in_valid in cycle t while the FSM is IDLE and the FIFO is empty.
REQ-022 SHALL insert exactly one LOAD cycle between back-to-back frames.
REQ-023 SHALL assert out_last only on the final byte of a frame: byte 15, or the CRC byte when the macro is defined.
REQ-024 SHALL keep the capture path independent of the serializer, so pushes continue during SEND and CRC.

Reset
REQ-025 SHALL, on rst=1 at a rising edge:
- set the FSM to IDLE;
- set both FIFO pointers to 0;
- set level=0, out_valid=0, out_data=8'h00, out_last=0 and overflow=0;
- clear the CRC accumulator to 8'h00.
REQ-026 SHALL, when reset is asserted mid-frame, abandon the frame; the aborted frame SHALL NOT resume after reset.
REQ-027 SHALL clear overflow only by reset.

Configuration
REQ-028 SHALL use the macro IOT_SER_CRC8_EN to control the CRC byte.
- Defined: a 17th byte is appended to each frame; CRC-8, poly 8'h07, init 8'h00, no reflection, no final XOR, computed over the 16 data bytes in transmit order.
- Undefined: frames are 16 bytes, and the CRC state and logic are absent.

Structure
REQ-029 SHALL place the following in package iot_ser_pkg:
- state enum type ser_state_t;
- constant BYTES_PER_WORD=16;
- constant CRC8_POLY=8'h07;
- constant CRC8_INIT=8'h00.
REQ-030 SHALL implement the FIFO as sub-module iot_ser_fifo, parameterized by DEPTH and WIDTH=128; FSM, shift register and CRC stay in the top.

Verification
REQ-031 SHALL cover single word, out_ready held at 1: in_data=128'h000102...0F, valid in cycle 0 -> out_valid from cycle 2, bytes 00..0F on consecutive cycles, out_last on byte 0F.
REQ-032 SHALL cover backpressure: out_ready toggled 1,0,0,1 repeatedly -> the byte sequence is unchanged, out_data is stable during stalls, and no byte is duplicated or skipped.
REQ-033 SHALL cover overflow with DEPTH=4 and out_ready=0: 5 words pushed -> level=4, overflow=1, and after release the first 4 words are emitted intact.
REQ-034 SHALL cover simultaneous push and pop: a push on the same edge as a LOAD pop at level=2 -> level stays 2.
REQ-035 SHALL cover the CRC option with IOT_SER_CRC8_EN defined: a word of 16 bytes of 8'h00 -> 17th byte 8'h00 with out_last; a word with bytes 00..0F -> 17th byte equals the reference CRC-8/0x07 model.
REQ-036 SHALL cover reset mid-frame: rst asserted after byte 5 -> next cycle out_valid=0, level=0, overflow=0, and no residual bytes appear after rst is released.
